// File: rtl/rmii_pkg.sv
// Shared constants and types for the RMII receive path: speed codes,
// CRC-32 constants, frame_error bit positions and the receiver FSM states.
package rmii_pkg;

    localparam logic [1:0] SPEED_CODE_10_MEGABIT  = 2'd0;
    localparam logic [1:0] SPEED_CODE_100_MEGABIT = 2'd1;

    localparam logic [31:0] CRC32_POLY_REFLECTED = 32'hEDB8_8320;
    localparam logic [31:0] CRC32_INIT           = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC32_RESIDUE        = 32'hDEBB_20E3;

    localparam int FCS_BYTES = 4;

    localparam int FRAME_ERROR_CRC   = 0;
    localparam int FRAME_ERROR_RUNT  = 1;
    localparam int FRAME_ERROR_GIANT = 2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RECEIVE,
        S_STATUS
    } rx_state_t;

    typedef struct packed {
        logic       good;
        logic [2:0] error;
    } frame_status_t;

endpackage

// File: rtl/ethernet_crc32_byte.sv
// Combinational CRC-32 step: folds one byte, LSB first, into the running
// reflected CRC register. Shared with the transmit path.
module ethernet_crc32_byte
    import rmii_pkg::*;
(
    input  logic [31:0] crc_current,
    input  logic [7:0]  data_byte,
    output logic [31:0] crc_next
);

    // Eight shift/xor steps of the reflected LFSR.
    always_comb begin
        crc_next = crc_current ^ {24'h0, data_byte};
        for (int i = 0; i < 8; i++) begin
            crc_next = crc_next[0] ? ((crc_next >> 1) ^ CRC32_POLY_REFLECTED) : (crc_next >> 1);
        end
    end

endmodule

// File: rtl/rmii_frame_receiver.sv
// RMII frame receiver: delimits frames from the packaged byte stream, checks
// CRC-32 and length, strips the FCS through a 4-byte delay line and emits
// payload bytes plus one end-of-frame status pulse.
// Optional: RMII_FRAME_RECEIVER_STATS_EN adds good/bad frame counters.
module rmii_frame_receiver
    import rmii_pkg::*;
#(
    parameter int MIN_FRAME_BYTES  = 64,
    parameter int MAX_FRAME_BYTES  = 1518,
    parameter int IDLE_TIMEOUT_100 = 8,
    parameter int IDLE_TIMEOUT_10  = 80
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [8:0]  packaged_data,
    input  logic        packaged_data_valid,
    input  logic [1:0]  speed_code,
    output logic [7:0]  frame_data,
    output logic        frame_data_valid,
    output logic        frame_data_first,
    output logic        frame_status_valid,
    output logic        frame_good,
    output logic [2:0]  frame_error
`ifdef RMII_FRAME_RECEIVER_STATS_EN
    ,
    output logic [31:0] good_frame_count,
    output logic [31:0] bad_frame_count
`endif
);

    localparam int IDLE_MAX = (IDLE_TIMEOUT_10 > IDLE_TIMEOUT_100) ? IDLE_TIMEOUT_10 : IDLE_TIMEOUT_100;
    localparam int IDLE_W   = $clog2(IDLE_MAX + 1);

    localparam logic [IDLE_W-1:0] TIMEOUT_100 = IDLE_W'(IDLE_TIMEOUT_100);
    localparam logic [IDLE_W-1:0] TIMEOUT_10  = IDLE_W'(IDLE_TIMEOUT_10);

    localparam logic [10:0] MIN_COUNT       = 11'(MIN_FRAME_BYTES);
    localparam logic [10:0] MAX_COUNT       = 11'(MAX_FRAME_BYTES);
    // Last byte count that still pushes a payload byte out of the delay line.
    localparam logic [10:0] LAST_COUNT      = 11'(MAX_FRAME_BYTES + FCS_BYTES);
    localparam logic [10:0] FIRST_OUT_COUNT = 11'(FCS_BYTES + 1);

    rx_state_t                    state, state_next;
    logic                         frame_open;   // bytes of a frame are being accepted
    logic                         speed_100;    // speed latched at frame start
    logic [10:0]                  byte_count, count_inc;
    logic [IDLE_W-1:0]            idle_count;
    logic [31:0]                  crc, crc_seed, crc_next;
    logic [FCS_BYTES-1:0][7:0]    delay_line;   // [0] newest, [FCS_BYTES-1] oldest
    logic                         byte_start, byte_more, timeout_hit, end_of_frame, data_fire;
    frame_status_t                status;

    // Input decode and datapath qualifiers.
    always_comb begin
        byte_start  = packaged_data_valid & packaged_data[8];
        byte_more   = packaged_data_valid & ~packaged_data[8] & frame_open;
        count_inc   = (byte_count == 11'h7FF) ? byte_count : byte_count + 11'd1;
        timeout_hit = idle_count >= (speed_100 ? TIMEOUT_100 : TIMEOUT_10);
        data_fire   = byte_more && (count_inc >= FIRST_OUT_COUNT) && (count_inc <= LAST_COUNT);
        crc_seed    = byte_start ? CRC32_INIT : crc;
    end

    ethernet_crc32_byte u_crc (
        .crc_current (crc_seed),
        .data_byte   (packaged_data[7:0]),
        .crc_next    (crc_next)
    );

    // Next-state and end-of-frame status; a flagged byte closes the old frame
    // and opens the new one in the same cycle.
    always_comb begin
        state_next                     = state;
        end_of_frame                   = 1'b0;
        status                         = '0;
        status.error[FRAME_ERROR_CRC]   = (crc != CRC32_RESIDUE);
        status.error[FRAME_ERROR_RUNT]  = (byte_count < MIN_COUNT);
        status.error[FRAME_ERROR_GIANT] = (byte_count > MAX_COUNT);
        status.good                    = ~|status.error;
        case (state)
            S_IDLE: begin
                if (byte_start) state_next = S_RECEIVE;
            end
            S_RECEIVE: begin
                if (byte_start || timeout_hit || (byte_count > LAST_COUNT)) begin
                    end_of_frame = 1'b1;
                    state_next   = S_STATUS;
                end
            end
            S_STATUS: begin
                state_next = (byte_start || frame_open) ? S_RECEIVE : S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    // Byte capture: CRC, byte count, delay line, idle counter, latched speed.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            frame_open <= 1'b0;
            speed_100  <= 1'b0;
            byte_count <= '0;
            idle_count <= '0;
            crc        <= CRC32_INIT;
            delay_line <= '0;
        end else begin
            if (byte_start) begin
                frame_open <= 1'b1;
                speed_100  <= (speed_code == SPEED_CODE_100_MEGABIT);
                byte_count <= 11'd1;
                crc        <= crc_next;
                delay_line <= {{(FCS_BYTES-1){8'h00}}, packaged_data[7:0]};
            end else begin
                if (byte_more) begin
                    byte_count <= count_inc;
                    crc        <= crc_next;
                    delay_line <= {delay_line[FCS_BYTES-2:0], packaged_data[7:0]};
                end
                if (end_of_frame) frame_open <= 1'b0;
            end
            if (packaged_data_valid)  idle_count <= '0;
            else if (idle_count != '1) idle_count <= idle_count + IDLE_W'(1);
        end
    end

    // Registered payload and status outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            frame_data         <= '0;
            frame_data_valid   <= 1'b0;
            frame_data_first   <= 1'b0;
            frame_status_valid <= 1'b0;
            frame_good         <= 1'b0;
            frame_error        <= '0;
        end else begin
            frame_data_valid   <= data_fire;
            frame_data_first   <= data_fire && (count_inc == FIRST_OUT_COUNT);
            if (data_fire) frame_data <= delay_line[FCS_BYTES-1];
            frame_status_valid <= end_of_frame;
            frame_good         <= end_of_frame & status.good;
            frame_error        <= end_of_frame ? status.error : 3'b000;
        end
    end

`ifdef RMII_FRAME_RECEIVER_STATS_EN
    // Good/bad frame tallies, wrapping at 2^32.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            good_frame_count <= '0;
            bad_frame_count  <= '0;
        end else if (frame_status_valid) begin
            if (frame_good) good_frame_count <= good_frame_count + 32'd1;
            else            bad_frame_count  <= bad_frame_count + 32'd1;
        end
    end
`endif

endmodule
